// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the streaming ALU.
package alu_pkg;

  localparam logic [3:0] OP_INCR  = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_SHL   = 4'd3;
  localparam logic [3:0] OP_SHR   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_AVG   = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_PASSB = 4'd9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
module alu_mul_iter #(
  parameter int WIDTH = 19
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               running;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc     <= '0;
        mcand   <= {{WIDTH{1'b0}}, a};
        mplier  <= b;
        cnt     <= CNT_W'(WIDTH);
        running <= 1'b1;
      end else if (running) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
        // The last partial product lands on this edge, so done pulses with the final sum.
        if (cnt == CNT_W'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/alu_stream.sv
// Handshaked ALU with registered result/flags; optional iterative MUL under ALU_MUL_EN.
// Handshake: a side transfers when valid && ready; results hold until out_valid && out_ready.
module alu_stream
  import alu_pkg::*;
#(
  parameter int WIDTH = 19,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             neg_flag,
  output logic             err_flag,
  output logic             busy
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

  logic               accept;
  logic               idle;
  logic               is_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   res_d;
  logic               carry_d;
  logic               err_d;
  logic [WIDTH:0]     avg_sum;

  assign accept   = in_valid && in_ready;
  assign in_ready = idle && (!out_valid || out_ready);

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    err_d   = 1'b0;
    avg_sum = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(1);
    case (alu_sel)
      SEL_W'(OP_INCR):  {carry_d, res_d} = {1'b0, a} + (WIDTH+1)'(1);
      SEL_W'(OP_ADD):   {carry_d, res_d} = {1'b0, a} + {1'b0, b};
      SEL_W'(OP_SUB):   {carry_d, res_d} = {1'b0, a} - {1'b0, b};
      SEL_W'(OP_SHL): begin
        if (b < W_VAL) {carry_d, res_d} = {1'b0, a} << b[SHAMT_W-1:0];
        else if (b == W_VAL) carry_d = a[WIDTH-1];
      end
      SEL_W'(OP_SHR): begin
        // A trailing guard bit catches the last bit shifted out.
        if (b < W_VAL) {res_d, carry_d} = {a, 1'b0} >> b[SHAMT_W-1:0];
        else if (b == W_VAL) carry_d = a[0];
      end
      SEL_W'(OP_OR):    res_d = a | b;
      SEL_W'(OP_AND):   res_d = a & b;
      SEL_W'(OP_AVG):   res_d = avg_sum[WIDTH:1];
      SEL_W'(OP_PASSB): res_d = b;
`ifdef ALU_MUL_EN
      SEL_W'(OP_MUL):   res_d = '0;
`endif
      default:          err_d = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  alu_state_t state, state_nxt;

  assign is_mul = (alu_sel == SEL_W'(OP_MUL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && is_mul) state_nxt = ST_BUSY;
      ST_BUSY: if (mul_done)         state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    idle = (state == ST_IDLE);
    busy = (state == ST_BUSY);
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign is_mul      = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
  assign idle        = 1'b1;
  assign busy        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      alu_result <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      neg_flag   <= 1'b0;
      err_flag   <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid  <= 1'b1;
      alu_result <= res_d;
      zero_flag  <= (res_d == '0);
      carry_flag <= carry_d;
      neg_flag   <= res_d[WIDTH-1];
      err_flag   <= err_d;
    end else if (mul_done) begin
      out_valid  <= 1'b1;
      alu_result <= mul_product[WIDTH-1:0];
      zero_flag  <= (mul_product[WIDTH-1:0] == '0);
      carry_flag <= |mul_product[2*WIDTH-1:WIDTH];
      neg_flag   <= mul_product[WIDTH-1];
      err_flag   <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_stream.sv
// Directed bench for alu_stream; MUL checks follow ALU_MUL_EN.
module tb_alu_stream;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_sel = '0;
  logic [18:0] a = '0;
  logic [18:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [18:0] alu_result;
  logic        zero_flag, carry_flag, neg_flag, err_flag, busy;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  alu_stream dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_sel(alu_sel), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .neg_flag(neg_flag), .err_flag(err_flag), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_res(input string tag, input logic [18:0] r,
                         input logic z, input logic c, input logic n, input logic e);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_result"}, 32'(alu_result), 32'(r));
    chk({tag, "_zero"}, 32'(zero_flag), 32'(z));
    chk({tag, "_carry"}, 32'(carry_flag), 32'(c));
    chk({tag, "_neg"}, 32'(neg_flag), 32'(n));
    chk({tag, "_err"}, 32'(err_flag), 32'(e));
  endtask

  // Presents one op at a negedge, waits (bounded) for in_ready, returns #1 after the accept edge.
  task automatic do_op(input logic [3:0] sel, input logic [18:0] va, input logic [18:0] vb);
    int guard;
    @(negedge clk);
    in_valid = 1'b1; alu_sel = sel; a = va; b = vb;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int lat;
    logic seen;

    // Reset state
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(alu_result), 32'd0);
    chk("rst_flags", 32'({zero_flag, carry_flag, neg_flag, err_flag}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    do_op(OP_ADD, 19'h7FFFF, 19'd1);          chk_res("add_wrap", 19'd0, 1, 1, 0, 0);
    do_op(OP_SUB, 19'd3, 19'd5);              chk_res("sub_borrow", 19'h7FFFE, 0, 1, 1, 0);
    do_op(OP_INCR, 19'd41, 19'd0);            chk_res("incr", 19'd42, 0, 0, 0, 0);
    do_op(OP_SHL, 19'd1, 19'd19);             chk_res("shl_w", 19'd0, 1, 0, 0, 0);
    do_op(OP_SHL, 19'd3, 19'd18);             chk_res("shl_18", 19'h40000, 0, 1, 1, 0);
    do_op(OP_SHR, 19'd8, 19'd3);              chk_res("shr_3", 19'd1, 0, 0, 0, 0);
    do_op(OP_SHR, 19'd5, 19'd1);              chk_res("shr_1", 19'd2, 0, 1, 0, 0);
    do_op(OP_SHR, 19'h7FFFF, 19'd20);         chk_res("shr_big", 19'd0, 1, 0, 0, 0);
    do_op(OP_SHL, 19'h7FFFF, 19'd0);          chk_res("shl_0", 19'h7FFFF, 0, 0, 1, 0);
    do_op(OP_OR, 19'h00F0F, 19'h0F0F0);       chk_res("or", 19'h0FFFF, 0, 0, 0, 0);
    do_op(OP_AND, 19'h4F0F0, 19'h7F00F);      chk_res("and", 19'h4F000, 0, 0, 1, 0);
    do_op(OP_AVG, 19'h7FFFF, 19'h7FFFF);      chk_res("avg_max", 19'h7FFFF, 0, 0, 1, 0);
    do_op(OP_AVG, 19'd2, 19'd3);              chk_res("avg_round", 19'd3, 0, 0, 0, 0);
    do_op(OP_PASSB, 19'd9, 19'h12345);        chk_res("passb", 19'h12345, 0, 0, 0, 0);
    do_op(4'd12, 19'd7, 19'd7);               chk_res("illegal", 19'd0, 1, 0, 0, 1);

    // Backpressure: result held, next op blocked until release cycle
    do_op(OP_ADD, 19'd2, 19'd2);
    out_ready = 1'b0;
    chk_res("bp_add", 19'd4, 0, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b1; alu_sel = OP_OR; a = 19'd1; b = 19'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_result", 32'(alu_result), 32'd4);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk); out_ready = 1'b1; #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_res("bp_next", 19'd3, 0, 0, 0, 0);

`ifdef ALU_MUL_EN
    do_op(OP_MUL, 19'd300, 19'd500);
    chk("mul_busy", 32'(busy), 32'd1);
    chk("mul_in_ready", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("mul_latency", 32'(lat), 32'd20);
    chk_res("mul", 19'd150000, 0, 0, 0, 0);
    chk("mul_busy_end", 32'(busy), 32'd0);

    do_op(OP_MUL, 19'd300, 19'd500);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mulrst_valid", 32'(out_valid), 32'd0);
    chk("mulrst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("mulrst_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mulrst_no_result", 32'(seen), 32'd0);
`else
    do_op(OP_MUL, 19'd300, 19'd500);
    chk_res("mul_off", 19'd0, 1, 0, 0, 1);
    chk("mul_off_busy", 32'(busy), 32'd0);
    lat = 0;
    seen = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
